fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
// PURPOSE
// - Synchronous single-clock FIFO: the parametrised successor of the fixed 8-deep FIFO.
// - Width and depth are generic. Adds programmable almost-full/almost-empty flags,
//   simultaneous read/write, and sticky overflow/underflow status.
// - Sits between a producer and a consumer inside one clock domain.
// - Replaces the separate next-state / output-logic / register split with one block.
// PARAMETERS
// - DATA_WIDTH  8  bits per entry.
// - DEPTH       8  number of entries; must be a power of 2 and >= 2.
// - AF_LEVEL    6  almost_full asserts when data_count >= AF_LEVEL (1..DEPTH-1).
// - AE_LEVEL    2  almost_empty asserts when data_count <= AE_LEVEL (1..DEPTH-1).
// - AW          $clog2(DEPTH)  pointer width; localparam.
// PORTS
// - clk           in   1           rising-edge clock.
// - rst           in   1           synchronous reset, active-high.
// - wr_en         in   1           write request, sampled each rising edge.
// - din           in   DATA_WIDTH  write data.
// - rd_en         in   1           read request, sampled each rising edge.
// - clr_sticky    in   1           clears ovf/udf.
// - dout          out  DATA_WIDTH  read data, registered.
// - data_count    out  AW+1        entries stored, 0..DEPTH.
// - full, empty   out  1           data_count==DEPTH / data_count==0.
// - almost_full   out  1           data_count >= AF_LEVEL.
// - almost_empty  out  1           data_count <= AE_LEVEL.
// - wr_ack, wr_err  out  1         1-cycle pulse: write accepted / rejected.
// - rd_ack, rd_err  out  1         1-cycle pulse: read accepted / rejected.
// - ovf, udf      out  1           sticky: a write was rejected / a read was rejected.
// BEHAVIOUR
// - Reset (rst=1 at an edge):
//   - Pointers 0, data_count 0, dout 0. empty=1, almost_empty=1; all other outputs 0.
//   - Memory contents are not cleared.
//   - rst overrides wr_en, rd_en and clr_sticky in the same cycle. Mid-operation reset
//     discards all stored data.
// - Registered outputs: every output is a register; flags and count reflect the state
//   after the current edge.
// - Write accept: wr_en & (!full | rd_en).
//   - Accept: mem[wptr]<=din, wptr+1 (wraps mod DEPTH), wr_ack=1 on the next cycle.
//   - Reject: wr_err=1 and ovf<=1; memory and count unchanged.
// - Read accept: rd_en & !empty.
//   - Accept: dout<=mem[rptr], rptr+1 (wraps), rd_ack=1.
//   - Latency: dout is valid the cycle after rd_en, aligned with rd_ack.
//   - Reject: rd_err=1, udf<=1, dout holds its last value.
// - Simultaneous wr_en & rd_en:
//   - Not empty (including full): both are accepted and data_count is unchanged.
//   - Empty: the write is accepted and the read is rejected (rd_err=1, no fall-through);
//     data_count becomes 1.
// - data_count:
//   - +1 on write-only accept, -1 on read-only accept, unchanged otherwise.
//   - Never exceeds DEPTH and never goes below 0.
// - Status registers (internal state, no FSM encoding required):
//   - EMPTY: count 0. PARTIAL: 0<count<DEPTH. FULL: count DEPTH.
//   - Transitions follow the accept rules above.
//   - Flags are recomputed from the next-state count, so they change on the same edge
//     as the count.
// - Sticky flags:
//   - clr_sticky=1 clears ovf/udf on the edge.
//   - If an error occurs in the same cycle as clr_sticky, the error wins and the flag is set.
// - Pointer wrap: AW-bit pointers wrap naturally. full/empty are derived from
//   data_count, not from pointer compare.
// - Idle (no wr_en, no rd_en): all ack/err outputs are 0 and everything else holds.
// TESTING
// - Reset: assert rst 2 cycles with wr_en=1 -> count=0, empty=1, almost_empty=1,
//   wr_ack=0, dout=0.
// - Fill: 8 writes 0x01..0x08 (DEPTH=8) -> 8 wr_ack pulses, count 8, full=1.
//   almost_full rises when count reaches 6; almost_empty falls when count reaches 3.
// - Overflow: 9th write while full -> wr_err=1 for 1 cycle, ovf=1 stays set, count=8.
//   clr_sticky -> ovf=0.
// - Drain order: 8 reads -> dout 0x01..0x08 in order, one cycle after each rd_en.
//   Then empty=1; a 9th read -> rd_err=1, udf=1, dout stays 0x08.
// - Simultaneous: at count=8, wr_en&rd_en with din=0xAA -> wr_ack=1, rd_ack=1,
//   count=8, 0xAA is read last.
//   At count=0, both asserted -> wr_ack=1, rd_err=1, count=1.
// - Wrap and reset: run 20 write/read cycles so the pointers wrap twice and the data
//   order holds. Then rst at count=5 -> count=0, empty=1, and the next write/read
//   returns the new data.

Source files
------------

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with a parameterised width and depth.
// It provides programmable almost-full and almost-empty flags,
// simultaneous read and write, and sticky overflow/underflow status.
// Every output is a register.
//
// Ports:
//   clk, rst           rising-edge clock; synchronous active-high reset
//   wr_en, din         write request and write data
//   rd_en              read request
//   clr_sticky         clears ovf/udf; an error in the same cycle still sets the flag
//   dout               read data, valid the cycle after an accepted rd_en
//   data_count         number of stored entries, 0..DEPTH
//   full, empty        data_count == DEPTH / data_count == 0
//   almost_full/_empty data_count >= AF_LEVEL / data_count <= AE_LEVEL
//   wr_ack, wr_err     one-cycle pulse: write accepted / rejected
//   rd_ack, rd_err     one-cycle pulse: read accepted / rejected
//   ovf, udf           sticky: a write / read was rejected
module fifo_sync_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic                      rd_en,
  input  logic                      clr_sticky,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic [$clog2(DEPTH):0]    data_count,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      wr_ack,
  output logic                      wr_err,
  output logic                      rd_ack,
  output logic                      rd_err,
  output logic                      ovf,
  output logic                      udf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic                  wr_acc, rd_acc;
  logic [AW:0]           count_nxt;

  // A write to a full FIFO is allowed when a read in the same cycle frees
  // a slot. A read of an empty FIFO is always rejected, so a write never
  // falls through to dout in the same cycle.
  assign wr_acc = wr_en & (~full | rd_en);
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    count_nxt = data_count;
    if (wr_acc && !rd_acc)      count_nxt = data_count + 1'b1;
    else if (!wr_acc && rd_acc) count_nxt = data_count - 1'b1;
  end

  // Storage has no reset, so reset leaves stale contents in place.
  // When the FIFO is full and a write and a read happen together,
  // wptr == rptr. The read path then sees the old entry, because both
  // updates are non-blocking.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      data_count   <= '0;
      dout         <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      wr_ack       <= 1'b0;
      wr_err       <= 1'b0;
      rd_ack       <= 1'b0;
      rd_err       <= 1'b0;
      ovf          <= 1'b0;
      udf          <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr];
      end
      data_count   <= count_nxt;
      // Flags are computed from the next count, so they move on the
      // same edge as data_count.
      full         <= (count_nxt == FULL_CNT);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_CNT);
      almost_empty <= (count_nxt <= AE_CNT);
      wr_ack       <= wr_acc;
      wr_err       <= wr_en & ~wr_acc;
      rd_ack       <= rd_acc;
      rd_err       <= rd_en & ~rd_acc;
      // If an error and clr_sticky occur together, the error wins.
      ovf          <= (ovf & ~clr_sticky) | (wr_en & ~wr_acc);
      udf          <= (udf & ~clr_sticky) | (rd_en & ~rd_acc);
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param in the default DEPTH=8 configuration:
// reset, fill, overflow, drain order, underflow, simultaneous read and
// write, pointer wrap and mid-operation reset.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, clr_sticky;
  logic [7:0] din, dout;
  logic [3:0] data_count;
  logic       full, empty, almost_full, almost_empty;
  logic       wr_ack, wr_err, rd_ack, rd_err, ovf, udf;

  int total = 0;
  int bad   = 0;

  fifo_sync_param #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .clr_sticky(clr_sticky), .dout(dout), .data_count(data_count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge. Outputs are sampled
  // 1 time unit after the edge that consumes those inputs.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
    wr_en = w; rd_en = r; din = d; clr_sticky = c;
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; clr_sticky = 0;
  endtask

  initial begin
    rst = 1; wr_en = 1; rd_en = 0; din = 8'h55; clr_sticky = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_count", data_count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae",    almost_empty, 1);
    chk("rst_wrack", wr_ack, 0);
    chk("rst_dout",  dout, 0);
    chk("rst_full",  full, 0);
    rst = 0; wr_en = 0;

    // fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 8'(i), 0);
      chk("fill_ack",   wr_ack, 1);
      chk("fill_count", data_count, i);
      chk("fill_af",    almost_full, (i >= 6));
      chk("fill_ae",    almost_empty, (i <= 2));
      chk("fill_full",  full, (i == 8));
    end

    // overflow
    cyc(1, 0, 8'h99, 0);
    chk("ovf_err",   wr_err, 1);
    chk("ovf_ack",   wr_ack, 0);
    chk("ovf_flag",  ovf, 1);
    chk("ovf_count", data_count, 8);
    cyc(0, 0, 8'h00, 0);
    chk("idle_err",  wr_err, 0);
    chk("idle_ack",  rd_ack, 0);
    chk("ovf_stick", ovf, 1);
    cyc(0, 0, 8'h00, 1);
    chk("ovf_clr",   ovf, 0);

    // drain order
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 8'h00, 0);
      chk("drain_ack",   rd_ack, 1);
      chk("drain_dout",  dout, i);
      chk("drain_count", data_count, 8 - i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_af",    almost_full, 0);

    // underflow
    cyc(0, 1, 8'h00, 0);
    chk("udf_err",  rd_err, 1);
    chk("udf_flag", udf, 1);
    chk("udf_dout", dout, 8'h08);
    chk("udf_ack",  rd_ack, 0);

    // simultaneous at empty; clr_sticky in the same cycle as the rejected read
    cyc(1, 1, 8'h10, 1);
    chk("sim0_wrack", wr_ack, 1);
    chk("sim0_rderr", rd_err, 1);
    chk("sim0_count", data_count, 1);
    chk("sim0_udf",   udf, 1);
    chk("sim0_dout",  dout, 8'h08);

    // refill to full, then simultaneous write and read at full
    for (int i = 1; i <= 7; i++) cyc(1, 0, 8'(8'h10 + i), 0);
    chk("refill_full", full, 1);
    cyc(1, 1, 8'hAA, 0);
    chk("simf_wrack", wr_ack, 1);
    chk("simf_rdack", rd_ack, 1);
    chk("simf_count", data_count, 8);
    chk("simf_dout",  dout, 8'h10);
    chk("simf_full",  full, 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 8'h00, 0);
      chk("simf_drain", dout, (i == 8) ? 8'hAA : 8'(8'h10 + i));
    end
    chk("simf_empty", empty, 1);

    // wrap: 20 write/read pairs move both pointers around the ring twice
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 8'(8'h30 + i), 0);
      cyc(0, 1, 8'h00, 0);
      chk("wrap_dout", dout, 8'(8'h30 + i));
    end
    chk("wrap_empty", empty, 1);

    // mid-operation reset at count 5
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h60 + i), 0);
    chk("pre_rst_count", data_count, 5);
    rst = 1;
    cyc(1, 1, 8'hEE, 1);
    rst = 0;
    chk("mrst_count", data_count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_dout",  dout, 0);
    cyc(1, 0, 8'h77, 0);
    cyc(0, 1, 8'h00, 0);
    chk("mrst_newdata", dout, 8'h77);
    chk("mrst_final",   data_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
